// File: rtl/step_profile_ctrl.sv
// step_profile_ctrl
//   Motion sequencer for the stepper drive path. Accepts a move command (direction, step
//   count), then issues one-cycle step_en pulses whose spacing follows a trapezoidal
//   accel/cruise/decel profile. A move stops on completion, abort (with a controlled decel)
//   or a limit switch in the direction of travel.
//
// Ports
//   sclk, s_rst           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only while idle
//   cmd_dir, cmd_steps    direction (1 = toward limit_r) and step count, sampled on accept
//   abort                 request a controlled decel stop of the running move
//   limit_r, limit_l      raw limit switches (asynchronous, synchronised internally)
//   step_en               one-cycle pulse per motor step
//   direct                direction to the motor driver, updated only on accept
//   busy                  high while a move is running
//   done                  one-cycle pulse when a move finishes (normal or aborted)
//   fault                 one-cycle pulse when a move is rejected or limit-stopped
//   pos_clr, pos          (STEP_POS_EN only) clear input and signed step position
//
// Build option
//   STEP_POS_EN  adds a signed position counter (pos) with synchronous clear (pos_clr).

module step_profile_ctrl #(
  parameter int unsigned W_STEPS   = 16,
  parameter int unsigned W_PER     = 20,
  parameter int unsigned PER_START = 50000,
  parameter int unsigned PER_MIN   = 5000,
  parameter int unsigned PER_STEP  = 500
) (
  input  logic                      sclk,
  input  logic                      s_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_dir,
  input  logic [W_STEPS-1:0]        cmd_steps,
  input  logic                      abort,
  input  logic                      limit_r,
  input  logic                      limit_l,
`ifdef STEP_POS_EN
  input  logic                      pos_clr,
  output logic signed [W_STEPS:0]   pos,
`endif
  output logic                      step_en,
  output logic                      direct,
  output logic                      busy,
  output logic                      done,
  output logic                      fault
);

  localparam logic [W_PER-1:0]   PerStart = W_PER'(PER_START);
  localparam logic [W_PER-1:0]   PerMin   = W_PER'(PER_MIN);
  localparam logic [W_PER-1:0]   PerStep  = W_PER'(PER_STEP);
  localparam logic [W_PER-1:0]   PerOne   = W_PER'(1);
  localparam logic [W_STEPS-1:0] CntOne   = W_STEPS'(1);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [1:0] {PhAccel, PhCruise, PhDecel} phase_e;

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic                 dir_q, dir_d;
  logic [W_STEPS-1:0]   rem_q, rem_d;
  logic [W_STEPS-1:0]   acc_q, acc_d;   // number of speed-up steps still to be undone
  logic [W_PER-1:0]     per_q, per_d;
  logic [W_PER-1:0]     tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic [1:0]           lim_r_sync, lim_l_sync;

  logic                 lim_r_s, lim_l_s;
  logic                 limit_hit;
  logic                 lim_cmd;
  logic [W_STEPS-1:0]   rem_new;

  assign lim_r_s   = lim_r_sync[1];
  assign lim_l_s   = lim_l_sync[1];
  assign limit_hit = dir_q ? lim_r_s : lim_l_s;
  assign lim_cmd   = cmd_dir ? lim_r_s : lim_l_s;
  assign rem_new   = rem_q - CntOne;

  // State register
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q    <= StIdle;
      phase_q    <= PhAccel;
      dir_q      <= 1'b0;
      rem_q      <= '0;
      acc_q      <= '0;
      per_q      <= '0;
      tick_q     <= '0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      lim_r_sync <= '0;
      lim_l_sync <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      per_q      <= per_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      lim_r_sync <= {lim_r_sync[0], limit_r};
      lim_l_sync <= {lim_l_sync[0], limit_l};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    per_d   = per_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    fault_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          rem_d   = cmd_steps;
          per_d   = PerStart;
          acc_d   = '0;
          tick_d  = '0;
          phase_d = PhAccel;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else if (lim_cmd) begin
            fault_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (step_en) begin
          tick_d = '0;
          rem_d  = rem_new;
          if (rem_new == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (rem_new <= acc_q) begin
            // Just enough steps left to undo every speed-up: slow down.
            phase_d = PhDecel;
            per_d   = per_q + PerStep;
            acc_d   = acc_q - CntOne;
          end else if ((phase_q == PhAccel) && (per_q > PerMin)) begin
            per_d = per_q - PerStep;
            acc_d = acc_q + CntOne;
            if ((per_q - PerStep) == PerMin) begin
              phase_d = PhCruise;
            end
          end
        end else begin
          tick_d = tick_q + PerOne;
        end

        // Completion takes priority over limit; abort acts on the post-step values.
        if (state_d == StRun) begin
          if (limit_hit) begin
            state_d = StIdle;
            fault_d = 1'b1;
          end else if (abort && (rem_d > acc_d)) begin
            rem_d = acc_d + CntOne;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q == StRun);
    step_en   = (state_q == StRun) && (tick_q == (per_q - PerOne));
    direct    = dir_q;
    done      = done_q;
    fault     = fault_q;
  end

`ifdef STEP_POS_EN
  localparam logic signed [W_STEPS:0] PosOne = (W_STEPS+1)'(1);

  logic signed [W_STEPS:0] pos_q;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      pos_q <= '0;
    end else if (pos_clr) begin
      pos_q <= '0;
    end else if (step_en) begin
      pos_q <= dir_q ? (pos_q + PosOne) : (pos_q - PosOne);
    end
  end

  assign pos = pos_q;
`endif

endmodule
